rans_word_packer: RTL and testbench
===================================

# rans_word_packer

Downstream stage of the multi-stream rANS encoder. Consumes the per-cycle renormalisation output (0–2 bytes tagged with a stream index) and accumulates bytes per stream into full words. Completed words go into an output FIFO with a valid/ready handshake toward the DMA/AXI-stream writer. A flush sequence drains partially filled words at end of block.

## Interface
- SYMBOL_WIDTH, 8, byte width; enc_i carries two bytes
- NUM_RANS, 4, number of interleaved streams (power of two, ≥2)
- WORD_BYTES, 4, bytes per output word
- FIFO_DEPTH, 8, output FIFO entries (power of two)
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- valid_i  in  2  bit0: enc_i[SW-1:0] valid; bit1: enc_i[2SW-1:SW] valid
- enc_i  in  2*SYMBOL_WIDTH  encoder output bytes
- stream_i  in  $clog2(NUM_RANS)  stream index of this cycle's bytes
- flush_i  in  1  single-cycle request to drain partial words
- word_o  out  WORD_BYTES*SYMBOL_WIDTH  packed word
- word_stream_o  out  $clog2(NUM_RANS)  stream index of word_o
- word_bytes_o  out  $clog2(WORD_BYTES)+1  valid bytes in word_o (1..WORD_BYTES)
- word_valid_o  out  1  FIFO head valid
- word_ready_i  in  1  consumer accepts head
- almost_full_o  out  1  FIFO free entries ≤ 1
- busy_o  out  1  flush in progress
- done_o  out  1  one-cycle pulse, flush finished
- overflow_o  out  1  sticky; a word was dropped

## Operation
- Per stream: byte buffer (WORD_BYTES−1 bytes) and fill count cnt[s] in 0..WORD_BYTES−1.
- Byte order: low byte (bit0) before high byte (bit1). The first byte of a word lands in word_o[SW-1:0], with ascending lanes thereafter.
- Each cycle with valid_i≠0 and FSM IDLE, append the valid bytes to stream stream_i.
  - If cnt+nbytes ≥ WORD_BYTES, form a word of WORD_BYTES bytes and push {word, stream_i, WORD_BYTES}.
  - The leftover byte (0 or 1) becomes the new buffer content with cnt = leftover.
  - At most one word per cycle.
- Push while FIFO full and no pop in the same cycle: drop the word and set overflow_o. Buffer still advances. Push and pop in the same cycle while full is accepted.
- overflow_o is cleared only by reset.
- FSM states:
  - IDLE: flush_i → FLUSH, idx=0.
  - FLUSH: at stream idx:
    - cnt[idx]=0 → skip.
    - Otherwise push {buffer zero-padded, idx, cnt[idx]} and clear cnt[idx]. If the FIFO is full, stall on that idx (no drop).
    - idx advances after a skip or successful push. After idx=NUM_RANS−1 → DONE.
  - DONE: done_o=1 for one cycle → IDLE.
- busy_o is high in FLUSH and DONE.
- valid_i≠0 while busy_o=1: bytes are discarded and overflow_o is set.
- flush_i while busy_o=1 is ignored.
- The FIFO pops when word_valid_o && word_ready_i.

## Timing
- Reset values:
  - All cnt=0, FIFO empty, FSM IDLE.
  - word_valid_o=0, word_o=0, word_stream_o=0, word_bytes_o=0.
  - almost_full_o=0, busy_o=0, done_o=0, overflow_o=0.
- Latency: word completed by inputs at cycle t → word_valid_o=1 at t+1 (FIFO empty, registered push, show-ahead head).
- busy_o rises the cycle after flush_i.
- With an empty FIFO, a flush takes NUM_RANS cycles in FLUSH plus 1 in DONE.
- almost_full_o and word_valid_o are registered/derived from the FIFO count only, with no combinational path from word_ready_i.
- Reset mid-flush or mid-word: all state cleared immediately; buffered bytes are lost.
- FIFO pointers wrap modulo FIFO_DEPTH. The count register distinguishes full from empty.

## Test plan
- Stream 2 receives valid=11 with enc=16'hBBAA, then valid=11 with enc=16'hDDCC.
  - Expect word_o=32'hDDCCBBAA, stream 2, bytes 4, one cycle after the second input.
- Stream 1 receives valid=01 enc=..11, valid=11 enc=3322, valid=11 enc=5544.
  - Expect word 32'h44332211. cnt[1]=1 with byte 55 retained.
  - Then flush → word 32'h00000055, bytes 1, stream 1, followed by done_o.
- Interleaved streams 0..3 each receive 2 bytes, round-robin, twice.
  - Expect four words in completion order 0,1,2,3 with correct per-stream contents.
- Hold word_ready_i=0 and complete FIFO_DEPTH+1 words.
  - Expect almost_full_o at count 7 and overflow_o=1.
  - Draining yields exactly 8 words; the 9th is dropped.
- Flush with FIFO full and 3 partial streams.
  - Expect the FSM to stall, no drops, and all 3 partials emitted after draining.
- Assert rst_ni mid-flush.
  - Expect all outputs at reset values asynchronously.
  - A subsequent flush produces no words and pulses done_o after NUM_RANS+1 cycles.

Source files
------------

// File: rtl/rans_word_packer_if.sv
// Bundle of the encoder-side input signals and the output-FIFO handshake of
// rans_word_packer. The packer itself uses the slave view; the producer and
// consumer side (encoder, DMA writer or bench) uses the master view.
interface rans_word_packer_if #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int NUM_RANS     = 4,
   parameter int WORD_BYTES   = 4
);
   localparam int SIW = $clog2(NUM_RANS);
   localparam int BW  = $clog2(WORD_BYTES) + 1;

   logic [1:0]                         valid_i;
   logic [2*SYMBOL_WIDTH-1:0]          enc_i;
   logic [SIW-1:0]                     stream_i;
   logic                               flush_i;
   logic [WORD_BYTES*SYMBOL_WIDTH-1:0] word_o;
   logic [SIW-1:0]                     word_stream_o;
   logic [BW-1:0]                      word_bytes_o;
   logic                               word_valid_o;
   logic                               word_ready_i;
   logic                               almost_full_o;
   logic                               busy_o;
   logic                               done_o;
   logic                               overflow_o;

   modport master (
      output valid_i, enc_i, stream_i, flush_i, word_ready_i,
      input  word_o, word_stream_o, word_bytes_o, word_valid_o,
             almost_full_o, busy_o, done_o, overflow_o
   );

   modport slave (
      input  valid_i, enc_i, stream_i, flush_i, word_ready_i,
      output word_o, word_stream_o, word_bytes_o, word_valid_o,
             almost_full_o, busy_o, done_o, overflow_o
   );
endinterface

// File: rtl/rans_word_packer.sv
// rans_word_packer: collects the 0..2 renormalisation bytes per cycle of each
// interleaved rANS stream into full words, queues them in a show-ahead FIFO,
// and on request drains the partially filled per-stream buffers.
module rans_word_packer #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int NUM_RANS     = 4,
   parameter int WORD_BYTES   = 4,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   rans_word_packer_if.slave    bus
);
   localparam int SW  = SYMBOL_WIDTH;
   localparam int SIW = $clog2(NUM_RANS);
   localparam int CW  = $clog2(WORD_BYTES) + 1;   // fill count and byte-count width
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int WW  = WORD_BYTES * SW;
   localparam int FW  = WW + SIW + CW;             // FIFO entry: {word, stream, bytes}

   typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_DONE} state_t;

   state_t         state_reg, state_next;
   logic [SIW-1:0] idx_reg, idx_next;

   logic [CW-1:0]  cnt_reg [NUM_RANS];
   logic [SW-1:0]  buf_reg [NUM_RANS][WORD_BYTES-1];

   logic [FW-1:0]  mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]    count_reg;
   logic           overflow_reg;

   // append path
   logic [CW-1:0]             cur_cnt;
   logic [1:0]                nbytes;
   logic [SW-1:0]             b0, b1;
   logic [CW:0]               total;
   logic [(WORD_BYTES+1)*SW-1:0] cat_vec;
   logic [WW-1:0]             flush_vec;
   logic                      append, word_complete;

   // FIFO control
   logic           flush_push, push, push_ok, pop, fifo_can_push, word_valid;
   logic [FW-1:0]  push_data, head;

   assign cur_cnt       = cnt_reg[bus.stream_i];
   assign nbytes        = {1'b0, bus.valid_i[0]} + {1'b0, bus.valid_i[1]};
   // A lone high byte is treated as the first new byte.
   assign b0            = bus.valid_i[0] ? bus.enc_i[SW-1:0] : bus.enc_i[2*SW-1:SW];
   assign b1            = bus.enc_i[2*SW-1:SW];
   assign total         = {1'b0, cur_cnt} + (CW+1)'(nbytes);
   assign append        = (state_reg == ST_IDLE) && (bus.valid_i != 2'b00);
   assign word_complete = append && (total >= (CW+1)'(WORD_BYTES));

   // Lane gi of the held bytes followed by this cycle's new bytes; lane
   // WORD_BYTES is the leftover when a word completes with a spare byte.
   for (genvar gi = 0; gi <= WORD_BYTES; gi++) begin : g_cat
      logic [SW-1:0] held;
      logic [SW-1:0] lane;
      if (gi < WORD_BYTES - 1) begin : g_held
         assign held = buf_reg[bus.stream_i][gi];
      end else begin : g_none
         assign held = '0;
      end
      // select buffered byte, first new byte or second new byte for this lane
      always_comb begin
         lane = '0;
         if (CW'(gi) < cur_cnt)                 lane = held;
         else if (CW'(gi) == cur_cnt)           lane = b0;
         else if (CW'(gi) == cur_cnt + CW'(1))  lane = b1;
      end
      assign cat_vec[gi*SW +: SW] = lane;
   end

   // Partial word of the stream being flushed, unused lanes forced to zero.
   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_flush
      if (gi < WORD_BYTES - 1) begin : g_lane
         assign flush_vec[gi*SW +: SW] =
            (CW'(gi) < cnt_reg[idx_reg]) ? buf_reg[idx_reg][gi] : '0;
      end else begin : g_top
         assign flush_vec[gi*SW +: SW] = '0;
      end
   end

   assign word_valid    = (count_reg != '0);
   assign pop           = word_valid && bus.word_ready_i;
   // Full FIFO still accepts a push when the head leaves in the same cycle.
   assign fifo_can_push = (count_reg != (AW+1)'(FIFO_DEPTH)) || pop;
   assign push          = word_complete || flush_push;
   assign push_ok       = push && fifo_can_push;
   assign push_data     = flush_push
                          ? {flush_vec, idx_reg, cnt_reg[idx_reg]}
                          : {cat_vec[WW-1:0], bus.stream_i, CW'(WORD_BYTES)};

   // flush sequencer: walk the streams, stall on a full FIFO, then pulse done
   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      flush_push = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (bus.flush_i) begin
               state_next = ST_FLUSH;
               idx_next   = '0;
            end
         end
         ST_FLUSH: begin
            if (cnt_reg[idx_reg] != '0) flush_push = 1'b1;
            if ((cnt_reg[idx_reg] == '0) || fifo_can_push) begin
               if (idx_reg == SIW'(NUM_RANS - 1)) state_next = ST_DONE;
               else                               idx_next   = idx_reg + SIW'(1);
            end
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // flush sequencer state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   // per-stream byte buffers and fill counts
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < NUM_RANS; s++) begin
            cnt_reg[s] <= '0;
            for (int b = 0; b < WORD_BYTES - 1; b++) buf_reg[s][b] <= '0;
         end
      end else begin
         if (append) begin
            if (word_complete) begin
               buf_reg[bus.stream_i][0] <= cat_vec[WORD_BYTES*SW +: SW];
               cnt_reg[bus.stream_i]    <= CW'(total - (CW+1)'(WORD_BYTES));
            end else begin
               for (int b = 0; b < WORD_BYTES - 1; b++)
                  buf_reg[bus.stream_i][b] <= cat_vec[b*SW +: SW];
               cnt_reg[bus.stream_i] <= CW'(total);
            end
         end
         if (flush_push && fifo_can_push) cnt_reg[idx_reg] <= '0;
      end
   end

   // FIFO storage; contents need no reset because the count gates the head
   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_reg] <= push_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // sticky loss flag: dropped word or bytes arriving during a flush
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_reg <= 1'b0;
      end else if ((word_complete && !fifo_can_push) ||
                   ((bus.valid_i != 2'b00) && (state_reg != ST_IDLE))) begin
         overflow_reg <= 1'b1;
      end
   end

   assign head              = mem[rd_ptr_reg];
   assign bus.word_valid_o  = word_valid;
   assign bus.word_o        = word_valid ? head[FW-1 -: WW] : '0;
   assign bus.word_stream_o = word_valid ? head[CW +: SIW]  : '0;
   assign bus.word_bytes_o  = word_valid ? head[CW-1:0]     : '0;
   assign bus.almost_full_o = (count_reg >= (AW+1)'(FIFO_DEPTH - 1));
   assign bus.busy_o        = (state_reg != ST_IDLE);
   assign bus.done_o        = (state_reg == ST_DONE);
   assign bus.overflow_o    = overflow_reg;
endmodule

// File: tb/tb_rans_word_packer.sv
// Directed bench for rans_word_packer: single-stream packing, partial flush,
// interleaved streams, FIFO overflow, flush stalled on a full FIFO and reset
// in the middle of a flush.
module tb_rans_word_packer;
   localparam int SW = 8;
   localparam int NR = 4;
   localparam int WB = 4;
   localparam int FD = 8;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   always #5 clk_i = ~clk_i;

   rans_word_packer_if #(.SYMBOL_WIDTH(SW), .NUM_RANS(NR), .WORD_BYTES(WB)) bus ();

   rans_word_packer #(
      .SYMBOL_WIDTH(SW), .NUM_RANS(NR), .WORD_BYTES(WB), .FIFO_DEPTH(FD)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send(input logic [1:0] v, input logic [15:0] e, input logic [1:0] s);
      bus.valid_i  = v;
      bus.enc_i    = e;
      bus.stream_i = s;
      tick();
      bus.valid_i  = 2'b00;
   endtask

   task automatic pop_one();
      bus.word_ready_i = 1'b1;
      tick();
      bus.word_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      bus.valid_i = 2'b00; bus.enc_i = '0; bus.stream_i = '0;
      bus.flush_i = 1'b0;  bus.word_ready_i = 1'b0;
      rst_ni = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({bus.word_valid_o, bus.almost_full_o, bus.busy_o, bus.done_o, bus.overflow_o} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {bus.word_valid_o, bus.almost_full_o, bus.busy_o, bus.done_o, bus.overflow_o});
      end
      vectors++;
      if ({bus.word_o, bus.word_stream_o, bus.word_bytes_o} !== '0) begin
         miscompares++;
         $display("FAIL reset_word: got %h/%0d/%0d expected 0/0/0",
                  bus.word_o, bus.word_stream_o, bus.word_bytes_o);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
   endtask

   task automatic test_single_stream();
      send(2'b11, 16'hBBAA, 2'd2);
      vectors++;
      if (bus.word_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early_valid: got %b expected 0", bus.word_valid_o);
      end
      send(2'b11, 16'hDDCC, 2'd2);
      vectors++;
      if ({bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o} !==
          {1'b1, 32'hDDCCBBAA, 2'd2, 3'd4}) begin
         miscompares++;
         $display("FAIL single_word: got v=%b %h s%0d b%0d expected v=1 ddccbbaa s2 b4",
                  bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o);
      end
      pop_one();
      vectors++;
      if (bus.word_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_pop: got valid %b expected 0", bus.word_valid_o);
      end
   endtask

   task automatic test_partial_flush();
      send(2'b01, 16'h0011, 2'd1);
      send(2'b11, 16'h3322, 2'd1);
      send(2'b11, 16'h5544, 2'd1);
      vectors++;
      if ({bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o} !==
          {1'b1, 32'h44332211, 2'd1, 3'd4}) begin
         miscompares++;
         $display("FAIL partial_word: got v=%b %h s%0d b%0d expected v=1 44332211 s1 b4",
                  bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o);
      end
      pop_one();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      vectors++;
      if (bus.busy_o !== 1'b1) begin
         miscompares++;
         $display("FAIL flush_busy: got %b expected 1", bus.busy_o);
      end
      // stream 0 skipped on the first FLUSH edge, stream 1 pushed on the second
      tick();
      tick();
      vectors++;
      if ({bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o} !==
          {1'b1, 32'h00000055, 2'd1, 3'd1}) begin
         miscompares++;
         $display("FAIL flush_word: got v=%b %h s%0d b%0d expected v=1 00000055 s1 b1",
                  bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o);
      end
      pop_one();
      tick();
      vectors++;
      if ({bus.done_o, bus.busy_o, bus.word_valid_o} !== 3'b110) begin
         miscompares++;
         $display("FAIL flush_done: got done/busy/valid %b expected 110",
                  {bus.done_o, bus.busy_o, bus.word_valid_o});
      end
      tick();
      vectors++;
      if ({bus.done_o, bus.busy_o} !== 2'b00) begin
         miscompares++;
         $display("FAIL flush_idle: got done/busy %b expected 00", {bus.done_o, bus.busy_o});
      end
   endtask

   task automatic test_interleave();
      logic [31:0] exp_w [4];
      exp_w = '{32'h04030201, 32'h14131211, 32'h24232221, 32'h34333231};
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < NR; s++)
            send(2'b11, {8'(s*16 + 2*r + 2), 8'(s*16 + 2*r + 1)}, 2'(s));
      for (int k = 0; k < NR; k++) begin
         vectors++;
         if ({bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o} !==
             {1'b1, exp_w[k], 2'(k), 3'd4}) begin
            miscompares++;
            $display("FAIL interleave_word%0d: got v=%b %h s%0d b%0d expected v=1 %h s%0d b4",
                     k, bus.word_valid_o, bus.word_o, bus.word_stream_o, bus.word_bytes_o,
                     exp_w[k], k);
         end
         pop_one();
      end
      vectors++;
      if (bus.word_valid_o !== 1'b0) begin
         miscompares++;
         $display("FAIL interleave_empty: got valid %b expected 0", bus.word_valid_o);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      vectors++;
      if (bus.overflow_o !== 1'b0) begin
         miscompares++;
         $display("FAIL overflow_pre: got %b expected 0", bus.overflow_o);
      end
      for (int k = 0; k <= FD; k++) begin
         send(2'b11, {8'(k*4 + 1), 8'(k*4)}, 2'd0);
         send(2'b11, {8'(k*4 + 3), 8'(k*4 + 2)}, 2'd0);
         if (k == FD - 3) begin
            vectors++;
            if (bus.almost_full_o !== 1'b0) begin
               miscompares++;
               $display("FAIL almost_full_at6: got %b expected 0", bus.almost_full_o);
            end
         end
         if (k == FD - 2) begin
            vectors++;
            if (bus.almost_full_o !== 1'b1) begin
               miscompares++;
               $display("FAIL almost_full_at7: got %b expected 1", bus.almost_full_o);
            end
         end
         if (k == FD - 1) begin
            vectors++;
            if (bus.overflow_o !== 1'b0) begin
               miscompares++;
               $display("FAIL overflow_at8: got %b expected 0", bus.overflow_o);
            end
         end
      end
      vectors++;
      if (bus.overflow_o !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_at9: got %b expected 1", bus.overflow_o);
      end
      for (int k = 0; k < FD; k++) begin
         exp = {8'(k*4 + 3), 8'(k*4 + 2), 8'(k*4 + 1), 8'(k*4)};
         vectors++;
         if ({bus.word_valid_o, bus.word_o} !== {1'b1, exp}) begin
            miscompares++;
            $display("FAIL overflow_drain%0d: got v=%b %h expected v=1 %h",
                     k, bus.word_valid_o, bus.word_o, exp);
         end
         pop_one();
      end
      vectors++;
      if ({bus.word_valid_o, bus.almost_full_o, bus.overflow_o} !== 3'b001) begin
         miscompares++;
         $display("FAIL overflow_after: got valid/af/ovf %b expected 001",
                  {bus.word_valid_o, bus.almost_full_o, bus.overflow_o});
      end
   endtask

   task automatic test_flush_full();
      logic [31:0] exp_w [11];
      logic [1:0]  exp_s [11];
      logic [2:0]  exp_b [11];
      int          n;
      bit          done_seen;
      for (int k = 0; k < FD; k++) begin
         exp_w[k] = {8'(8'h43 + k*4), 8'(8'h42 + k*4), 8'(8'h41 + k*4), 8'(8'h40 + k*4)};
         exp_s[k] = 2'd2;
         exp_b[k] = 3'd4;
      end
      exp_w[8]  = 32'h000000A1; exp_s[8]  = 2'd0; exp_b[8]  = 3'd1;
      exp_w[9]  = 32'h0000B2B1; exp_s[9]  = 2'd1; exp_b[9]  = 3'd2;
      exp_w[10] = 32'h000000C1; exp_s[10] = 2'd3; exp_b[10] = 3'd1;

      send(2'b01, 16'h00A1, 2'd0);
      send(2'b10, 16'hC100, 2'd3);
      send(2'b11, 16'hB2B1, 2'd1);
      for (int k = 0; k < FD; k++) begin
         send(2'b11, {8'(8'h41 + k*4), 8'(8'h40 + k*4)}, 2'd2);
         send(2'b11, {8'(8'h43 + k*4), 8'(8'h42 + k*4)}, 2'd2);
      end
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      done_seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (bus.done_o) done_seen = 1'b1;
         tick();
      end
      vectors++;
      if ({bus.busy_o, done_seen} !== 2'b10) begin
         miscompares++;
         $display("FAIL flush_full_stall: got busy/done_seen %b expected 10", {bus.busy_o, done_seen});
      end
      n = 0;
      bus.word_ready_i = 1'b1;
      for (int c = 0; c < 60 && !(done_seen && n >= 11); c++) begin
         if (bus.done_o) done_seen = 1'b1;
         if (bus.word_valid_o) begin
            if (n < 11) begin
               vectors++;
               if ({bus.word_o, bus.word_stream_o, bus.word_bytes_o} !== {exp_w[n], exp_s[n], exp_b[n]}) begin
                  miscompares++;
                  $display("FAIL flush_full_word%0d: got %h s%0d b%0d expected %h s%0d b%0d",
                           n, bus.word_o, bus.word_stream_o, bus.word_bytes_o,
                           exp_w[n], exp_s[n], exp_b[n]);
               end
            end
            n++;
         end
         tick();
      end
      bus.word_ready_i = 1'b0;
      vectors++;
      if (n != 11 || !done_seen) begin
         miscompares++;
         $display("FAIL flush_full_count: got %0d words done_seen %b expected 11 words done_seen 1",
                  n, done_seen);
      end
   endtask

   task automatic test_reset_mid_flush();
      send(2'b01, 16'h0077, 2'd0);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      tick();
      vectors++;
      if ({bus.word_valid_o, bus.busy_o} !== 2'b11) begin
         miscompares++;
         $display("FAIL midflush_pre: got valid/busy %b expected 11", {bus.word_valid_o, bus.busy_o});
      end
      #2 rst_ni = 1'b0;
      #1;
      vectors++;
      if ({bus.word_valid_o, bus.almost_full_o, bus.busy_o, bus.done_o, bus.overflow_o,
           bus.word_o, bus.word_stream_o, bus.word_bytes_o} !== '0) begin
         miscompares++;
         $display("FAIL midflush_async: got v%b af%b busy%b done%b ovf%b %h s%0d b%0d expected all zero",
                  bus.word_valid_o, bus.almost_full_o, bus.busy_o, bus.done_o, bus.overflow_o,
                  bus.word_o, bus.word_stream_o, bus.word_bytes_o);
      end
      #2 rst_ni = 1'b1;
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      repeat (NR - 1) tick();
      vectors++;
      if (bus.done_o !== 1'b0) begin
         miscompares++;
         $display("FAIL empty_flush_early: got done %b expected 0", bus.done_o);
      end
      tick();
      vectors++;
      if ({bus.done_o, bus.word_valid_o} !== 2'b10) begin
         miscompares++;
         $display("FAIL empty_flush_done: got done/valid %b expected 10", {bus.done_o, bus.word_valid_o});
      end
      tick();
      vectors++;
      if ({bus.done_o, bus.busy_o, bus.word_valid_o} !== 3'b000) begin
         miscompares++;
         $display("FAIL empty_flush_end: got done/busy/valid %b expected 000",
                  {bus.done_o, bus.busy_o, bus.word_valid_o});
      end
   endtask

   initial begin
      test_reset();
      test_single_stream();
      test_partial_flush();
      test_interleave();
      test_overflow();
      test_flush_full();
      test_reset_mid_flush();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
